// File: rtl/vpifo_req_scheduler.sv
// Per-lane round-robin issue of push/pop requests into the PIFO tree, with per-tree tag FIFOs
// that route level-0 pop results back to their requester (issue: comb, response: 1 cycle).
module vpifo_req_scheduler #(
  parameter int NREQ      = 4,
  parameter int LEVEL     = 4,
  parameter int TREE_NUM  = 4,
  parameter int PTW       = 16,
  parameter int MTW       = 0,
  parameter int TAG_DEPTH = 8,
  localparam int DW = PTW + MTW,
  localparam int TW = (TREE_NUM > 1) ? $clog2(TREE_NUM) : 1,
  localparam int RW = (NREQ > 1) ? $clog2(NREQ) : 1,
  localparam int LW = (LEVEL > 1) ? $clog2(LEVEL) : 1,
  localparam int AW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1,
  localparam int PW = AW + 1
) (
  input  logic                     i_clk,
  input  logic                     i_arst_n,
  input  logic [NREQ-1:0]          i_req_valid,
  input  logic [NREQ-1:0]          i_req_op,
  input  logic [NREQ*TW-1:0]       i_req_tree,
  input  logic [NREQ*DW-1:0]       i_req_data,
  output logic [NREQ-1:0]          o_req_ready,
  output logic [LEVEL-1:0]         o_push,
  output logic [LEVEL-1:0]         o_pop,
  output logic [LEVEL*TW-1:0]      o_tree_id,
  output logic [LEVEL*DW-1:0]      o_push_data,
  input  logic [LEVEL-1:0]         i_task_fifo_full,
  input  logic [LEVEL-1:0]         i_is_level0_pop,
  input  logic [LEVEL*TW-1:0]      i_pop_tree_id,
  input  logic [LEVEL*DW-1:0]      i_pop_data,
  output logic [LEVEL-1:0]         o_rsp_valid,
  output logic [LEVEL*RW-1:0]      o_rsp_req,
  output logic [LEVEL*TW-1:0]      o_rsp_tree,
  output logic [LEVEL*DW-1:0]      o_rsp_data,
  output logic [TREE_NUM*PW-1:0]   o_pending,
  output logic                     o_err_orphan
);

  logic [LEVEL-1:0][RW-1:0]                   rr_q, rr_d;
  logic [TREE_NUM-1:0][TAG_DEPTH-1:0][RW-1:0] tag_q, tag_d;
  logic [TREE_NUM-1:0][PW-1:0]                wp_q, wp_d, rp_q, rp_d;
  logic [LEVEL-1:0]                           rsp_valid_q, rsp_valid_d;
  logic [LEVEL-1:0][RW-1:0]                   rsp_req_q, rsp_req_d;
  logic [LEVEL-1:0][TW-1:0]                   rsp_tree_q, rsp_tree_d;
  logic [LEVEL-1:0][DW-1:0]                   rsp_data_q, rsp_data_d;
  logic                                       err_q, err_d;

  logic [TREE_NUM-1:0]         tag_full, tag_empty;
  logic [TREE_NUM-1:0][PW-1:0] pend;
  logic [NREQ-1:0][TW-1:0]     req_tree;
  logic [NREQ-1:0][LW-1:0]     req_lane;
  logic [NREQ-1:0]             elig, gnt;
  logic [LEVEL-1:0]            push_l, pop_l;
  logic [LEVEL-1:0][TW-1:0]    tid_l;
  logic [LEVEL-1:0][DW-1:0]    pdat_l;

  // Full when the wrap bits differ but the addresses match.
  always_comb begin
    for (int t = 0; t < TREE_NUM; t++) begin
      tag_full[t]  = (wp_q[t][PW-1] != rp_q[t][PW-1]) && (wp_q[t][AW-1:0] == rp_q[t][AW-1:0]);
      tag_empty[t] = (wp_q[t] == rp_q[t]);
      pend[t]      = wp_q[t] - rp_q[t];
    end
  end

  always_comb begin
    for (int r = 0; r < NREQ; r++) begin
      req_tree[r] = i_req_tree[r*TW +: TW];
      req_lane[r] = LW'(int'(req_tree[r]) % LEVEL);
      elig[r]     = i_req_valid[r] && !i_task_fifo_full[req_lane[r]] &&
                    (i_req_op[r] || !tag_full[req_tree[r]]);
    end
  end

  always_comb begin
    logic found;
    int   r;
    found  = 1'b0;
    r      = 0;
    gnt    = '0;
    push_l = '0;
    pop_l  = '0;
    tid_l  = '0;
    pdat_l = '0;
    rr_d   = rr_q;
    tag_d  = tag_q;
    wp_d   = wp_q;
    for (int l = 0; l < LEVEL; l++) begin
      found = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
        r = (int'(rr_q[l]) + k) % NREQ;
        if (!found && elig[r] && (req_lane[r] == LW'(l))) begin
          found    = 1'b1;
          gnt[r]   = 1'b1;
          rr_d[l]  = RW'((r + 1) % NREQ);
          tid_l[l] = req_tree[r];
          if (i_req_op[r]) begin
            push_l[l] = 1'b1;
            pdat_l[l] = i_req_data[r*DW +: DW];
          end else begin
            pop_l[l] = 1'b1;
            tag_d[req_tree[r]][wp_q[req_tree[r]][AW-1:0]] = RW'(r);
            wp_d[req_tree[r]] = wp_q[req_tree[r]] + PW'(1);
          end
        end
      end
    end
  end

  // A return with nothing outstanding is flagged and otherwise dropped.
  always_comb begin
    logic [TW-1:0] t;
    t           = '0;
    rp_d        = rp_q;
    err_d       = err_q;
    rsp_valid_d = '0;
    rsp_req_d   = '0;
    rsp_tree_d  = '0;
    rsp_data_d  = '0;
    for (int k = 0; k < LEVEL; k++) begin
      t = i_pop_tree_id[k*TW +: TW];
      if (i_is_level0_pop[k]) begin
        if (tag_empty[t]) begin
          err_d = 1'b1;
        end else begin
          rsp_valid_d[k] = 1'b1;
          rsp_req_d[k]   = tag_q[t][rp_q[t][AW-1:0]];
          rsp_tree_d[k]  = t;
          rsp_data_d[k]  = i_pop_data[k*DW +: DW];
          rp_d[t]        = rp_q[t] + PW'(1);
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      rr_q        <= '0;
      tag_q       <= '0;
      wp_q        <= '0;
      rp_q        <= '0;
      rsp_valid_q <= '0;
      rsp_req_q   <= '0;
      rsp_tree_q  <= '0;
      rsp_data_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      rr_q        <= rr_d;
      tag_q       <= tag_d;
      wp_q        <= wp_d;
      rp_q        <= rp_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_req_q   <= rsp_req_d;
      rsp_tree_q  <= rsp_tree_d;
      rsp_data_q  <= rsp_data_d;
      err_q       <= err_d;
    end
  end

  assign o_req_ready  = gnt & {NREQ{i_arst_n}};
  assign o_push       = push_l & {LEVEL{i_arst_n}};
  assign o_pop        = pop_l & {LEVEL{i_arst_n}};
  assign o_tree_id    = tid_l & {(LEVEL*TW){i_arst_n}};
  assign o_push_data  = pdat_l & {(LEVEL*DW){i_arst_n}};
  assign o_rsp_valid  = rsp_valid_q;
  assign o_rsp_req    = rsp_req_q;
  assign o_rsp_tree   = rsp_tree_q;
  assign o_rsp_data   = rsp_data_q;
  assign o_pending    = pend;
  assign o_err_orphan = err_q;

endmodule

// File: tb/tb_vpifo_req_scheduler.sv
// Directed bench for vpifo_req_scheduler: fairness, parallel lanes, backpressure, routing, tag full, orphan/reset.
module tb_vpifo_req_scheduler;

  logic        i_clk = 1'b0;
  logic        i_arst_n;
  logic [3:0]  i_req_valid, i_req_op;
  logic [7:0]  i_req_tree;
  logic [63:0] i_req_data;
  logic [3:0]  o_req_ready, o_push, o_pop;
  logic [7:0]  o_tree_id;
  logic [63:0] o_push_data;
  logic [3:0]  i_task_fifo_full, i_is_level0_pop;
  logic [7:0]  i_pop_tree_id;
  logic [63:0] i_pop_data;
  logic [3:0]  o_rsp_valid;
  logic [7:0]  o_rsp_req, o_rsp_tree;
  logic [63:0] o_rsp_data;
  logic [15:0] o_pending;
  logic        o_err_orphan;

  int total = 0;
  int bad   = 0;

  always #5 i_clk = ~i_clk;

  vpifo_req_scheduler dut (
    .i_clk(i_clk), .i_arst_n(i_arst_n),
    .i_req_valid(i_req_valid), .i_req_op(i_req_op), .i_req_tree(i_req_tree), .i_req_data(i_req_data),
    .o_req_ready(o_req_ready), .o_push(o_push), .o_pop(o_pop), .o_tree_id(o_tree_id),
    .o_push_data(o_push_data), .i_task_fifo_full(i_task_fifo_full),
    .i_is_level0_pop(i_is_level0_pop), .i_pop_tree_id(i_pop_tree_id), .i_pop_data(i_pop_data),
    .o_rsp_valid(o_rsp_valid), .o_rsp_req(o_rsp_req), .o_rsp_tree(o_rsp_tree),
    .o_rsp_data(o_rsp_data), .o_pending(o_pending), .o_err_orphan(o_err_orphan)
  );

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_req_valid = '0; i_req_op = '0; i_req_tree = '0; i_req_data = '0;
    i_task_fifo_full = '0; i_is_level0_pop = '0; i_pop_tree_id = '0; i_pop_data = '0;
  endtask

  task automatic set_req(input int r, input logic op, input logic [1:0] tree, input logic [15:0] dat);
    i_req_valid[r] = 1'b1;
    i_req_op[r] = op;
    i_req_tree[r*2 +: 2] = tree;
    i_req_data[r*16 +: 16] = dat;
  endtask

  task automatic set_ret(input int k, input logic [1:0] tree, input logic [15:0] dat);
    i_is_level0_pop[k] = 1'b1;
    i_pop_tree_id[k*2 +: 2] = tree;
    i_pop_data[k*16 +: 16] = dat;
  endtask

  task automatic test_reset();
    idle_inputs();
    i_arst_n = 1'b0;
    set_req(0, 1'b1, 2'd0, 16'h1234);
    #3;
    total++;
    if (o_req_ready !== 4'b0000 || o_push !== 4'b0000 || o_push_data !== 64'd0) begin
      bad++; $display("FAIL reset_comb ready=%b push=%b data=%h required 0", o_req_ready, o_push, o_push_data);
    end
    total++;
    if (o_rsp_valid !== 4'd0 || o_rsp_req !== 8'd0 || o_rsp_data !== 64'd0 || o_pending !== 16'd0 || o_err_orphan !== 1'b0) begin
      bad++; $display("FAIL reset_regs rsp_valid=%b rsp_req=%h pending=%h err=%b required 0",
                      o_rsp_valid, o_rsp_req, o_pending, o_err_orphan);
    end
    #9;
    idle_inputs();
    i_arst_n = 1'b1;
    step();
  endtask

  task automatic test_fairness();
    for (int r = 0; r < 4; r++) set_req(r, 1'b1, 2'd1, 16'h0100 + 16'(r));
    for (int c = 0; c < 8; c++) begin
      #2;
      total++;
      if (o_req_ready !== (4'b0001 << (c % 4)) || o_push !== 4'b0010 || o_pop !== 4'b0000) begin
        bad++; $display("FAIL fairness c=%0d ready=%b push=%b required ready=%b push=0010",
                        c, o_req_ready, o_push, 4'b0001 << (c % 4));
      end
      total++;
      if (o_push_data[31:16] !== 16'h0100 + 16'(c % 4) || o_tree_id[3:2] !== 2'd1) begin
        bad++; $display("FAIL fairness_data c=%0d data=%h tree=%0d required %h tree=1",
                        c, o_push_data[31:16], o_tree_id[3:2], 16'h0100 + 16'(c % 4));
      end
      step();
    end
    idle_inputs();
  endtask

  task automatic test_parallel();
    for (int r = 0; r < 4; r++) set_req(r, 1'b1, 2'(r), 16'h1000 + 16'(r));
    #2;
    total++;
    if (o_req_ready !== 4'b1111 || o_push !== 4'b1111) begin
      bad++; $display("FAIL parallel ready=%b push=%b required 1111/1111", o_req_ready, o_push);
    end
    total++;
    if (o_push_data !== 64'h1003_1002_1001_1000 || o_tree_id !== 8'b11_10_01_00) begin
      bad++; $display("FAIL parallel_data data=%h tree=%b required 1003100210011000 11100100", o_push_data, o_tree_id);
    end
    step();
    idle_inputs();
  endtask

  task automatic test_backpressure();
    set_req(1, 1'b1, 2'd2, 16'h2222);
    i_task_fifo_full[2] = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #2;
      total++;
      if (o_req_ready !== 4'b0000 || o_push !== 4'b0000) begin
        bad++; $display("FAIL backpressure c=%0d ready=%b push=%b required 0000", c, o_req_ready, o_push);
      end
      step();
    end
    i_task_fifo_full[2] = 1'b0;
    #2;
    total++;
    if (o_req_ready !== 4'b0010 || o_push !== 4'b0100 || o_push_data[47:32] !== 16'h2222) begin
      bad++; $display("FAIL bp_release ready=%b push=%b data=%h required 0010 0100 2222",
                      o_req_ready, o_push, o_push_data[47:32]);
    end
    step();
    idle_inputs();
  endtask

  task automatic test_routing();
    set_req(2, 1'b0, 2'd3, 16'hFFFF);
    #2;
    total++;
    if (o_req_ready !== 4'b0100 || o_pop !== 4'b1000 || o_push !== 4'b0000 ||
        o_tree_id[7:6] !== 2'd3 || o_push_data[63:48] !== 16'd0) begin
      bad++; $display("FAIL route_pop2 ready=%b pop=%b tree=%0d data=%h required 0100 1000 3 0000",
                      o_req_ready, o_pop, o_tree_id[7:6], o_push_data[63:48]);
    end
    step();
    total++;
    if (o_pending[15:12] !== 4'd1) begin
      bad++; $display("FAIL route_pend1 pending=%0d required 1", o_pending[15:12]);
    end
    idle_inputs();
    set_req(0, 1'b0, 2'd3, 16'h0);
    #2;
    total++;
    if (o_req_ready !== 4'b0001 || o_pop !== 4'b1000) begin
      bad++; $display("FAIL route_pop0 ready=%b pop=%b required 0001 1000", o_req_ready, o_pop);
    end
    step();
    total++;
    if (o_pending[15:12] !== 4'd2) begin
      bad++; $display("FAIL route_pend2 pending=%0d required 2", o_pending[15:12]);
    end
    idle_inputs();
    set_ret(3, 2'd3, 16'h00AA);
    #2;
    total++;
    if (o_rsp_valid !== 4'b0000) begin
      bad++; $display("FAIL route_early rsp_valid=%b required 0000", o_rsp_valid);
    end
    step();
    total++;
    if (o_rsp_valid !== 4'b1000 || o_rsp_req[7:6] !== 2'd2 || o_rsp_data[63:48] !== 16'h00AA ||
        o_rsp_tree[7:6] !== 2'd3 || o_pending[15:12] !== 4'd1) begin
      bad++; $display("FAIL route_rsp1 valid=%b req=%0d data=%h tree=%0d pend=%0d required 1000 2 00aa 3 1",
                      o_rsp_valid, o_rsp_req[7:6], o_rsp_data[63:48], o_rsp_tree[7:6], o_pending[15:12]);
    end
    set_ret(3, 2'd3, 16'h00BB);
    step();
    total++;
    if (o_rsp_valid !== 4'b1000 || o_rsp_req[7:6] !== 2'd0 || o_rsp_data[63:48] !== 16'h00BB ||
        o_pending[15:12] !== 4'd0) begin
      bad++; $display("FAIL route_rsp2 valid=%b req=%0d data=%h pend=%0d required 1000 0 00bb 0",
                      o_rsp_valid, o_rsp_req[7:6], o_rsp_data[63:48], o_pending[15:12]);
    end
    idle_inputs();
    step();
    total++;
    if (o_rsp_valid !== 4'b0000) begin
      bad++; $display("FAIL route_idle rsp_valid=%b required 0000", o_rsp_valid);
    end
  endtask

  task automatic test_tag_full();
    set_req(0, 1'b0, 2'd0, 16'h0);
    for (int i = 0; i < 8; i++) begin
      #2;
      total++;
      if (o_req_ready !== 4'b0001 || o_pop !== 4'b0001) begin
        bad++; $display("FAIL tag_fill i=%0d ready=%b pop=%b required 0001 0001", i, o_req_ready, o_pop);
      end
      step();
    end
    total++;
    if (o_pending[3:0] !== 4'd8) begin
      bad++; $display("FAIL tag_pend8 pending=%0d required 8", o_pending[3:0]);
    end
    set_ret(0, 2'd0, 16'h5555);
    #2;
    total++;
    if (o_req_ready !== 4'b0000 || o_pop !== 4'b0000) begin
      bad++; $display("FAIL tag_full ready=%b pop=%b required 0000", o_req_ready, o_pop);
    end
    step();
    i_is_level0_pop = '0;
    total++;
    if (o_pending[3:0] !== 4'd7 || o_rsp_valid !== 4'b0001 || o_rsp_req[1:0] !== 2'd0) begin
      bad++; $display("FAIL tag_free pend=%0d valid=%b req=%0d required 7 0001 0",
                      o_pending[3:0], o_rsp_valid, o_rsp_req[1:0]);
    end
    #2;
    total++;
    if (o_req_ready !== 4'b0001) begin
      bad++; $display("FAIL tag_ninth ready=%b required 0001", o_req_ready);
    end
    step();
    total++;
    if (o_pending[3:0] !== 4'd8) begin
      bad++; $display("FAIL tag_refill pending=%0d required 8", o_pending[3:0]);
    end
    idle_inputs();
  endtask

  task automatic test_orphan_reset();
    set_ret(1, 2'd1, 16'h7777);
    step();
    i_is_level0_pop = '0;
    total++;
    if (o_rsp_valid !== 4'b0000 || o_err_orphan !== 1'b1 || o_pending[7:4] !== 4'd0) begin
      bad++; $display("FAIL orphan valid=%b err=%b pend=%0d required 0000 1 0", o_rsp_valid, o_err_orphan, o_pending[7:4]);
    end
    step();
    total++;
    if (o_err_orphan !== 1'b1) begin
      bad++; $display("FAIL orphan_sticky err=%b required 1", o_err_orphan);
    end
    for (int r = 0; r < 4; r++) set_req(r, 1'b1, 2'd1, 16'h3000 + 16'(r));
    #2;
    i_arst_n = 1'b0;
    #1;
    total++;
    if (o_err_orphan !== 1'b0 || o_pending !== 16'd0 || o_rsp_valid !== 4'd0 ||
        o_req_ready !== 4'd0 || o_push !== 4'd0 || o_tree_id !== 8'd0) begin
      bad++; $display("FAIL midreset err=%b pend=%h rsp=%b ready=%b push=%b tree=%h required all 0",
                      o_err_orphan, o_pending, o_rsp_valid, o_req_ready, o_push, o_tree_id);
    end
    step();
    #2;
    i_arst_n = 1'b1;
    #1;
    total++;
    if (o_req_ready !== 4'b0001 || o_push !== 4'b0010 || o_push_data[31:16] !== 16'h3000) begin
      bad++; $display("FAIL ptr_after_reset ready=%b push=%b data=%h required 0001 0010 3000",
                      o_req_ready, o_push, o_push_data[31:16]);
    end
    step();
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_fairness();
    test_parallel();
    test_backpressure();
    test_routing();
    test_tag_full();
    test_orphan_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vpifo_req_scheduler.md
# vpifo_req_scheduler

Front-end scheduler for the virtualized multi-tree PIFO. It arbitrates push/pop requests from NREQ requesters onto the LEVEL per-lane task inputs of the PIFO tree top, and holds off any lane whose task FIFO is full. It tracks outstanding pops per tree and routes each level-0 pop result back to the requester that issued it. It sits between the host/tenant ports and the PIFO tree top.

## Interface
- NREQ, 4, number of requesters
- LEVEL, 4, lanes (RPUs) in the PIFO tree; power of two
- TREE_NUM, 4, logical trees; power of two, ≥ LEVEL
- PTW, 16, payload width
- MTW, 0, metadata width
- TAG_DEPTH, 8, per-tree outstanding-pop capacity; power of two
- i_clk  in  1  clock
- i_arst_n  in  1  reset, asynchronous, active-low
- i_req_valid  in  NREQ  request valid, one bit per requester
- i_req_op  in  NREQ  1 = push, 0 = pop
- i_req_tree  in  NREQ*log2(TREE_NUM)  target tree, requester r at slice r
- i_req_data  in  NREQ*(PTW+MTW)  push data; ignored for pop
- o_req_ready  out  NREQ  request accepted this cycle
- o_push  out  LEVEL  push to lane
- o_pop  out  LEVEL  pop to lane
- o_tree_id  out  LEVEL*log2(TREE_NUM)  tree id per lane
- o_push_data  out  LEVEL*(PTW+MTW)  push data per lane
- i_task_fifo_full  in  LEVEL  lane task FIFO full
- i_is_level0_pop  in  LEVEL  lane returned a pop result
- i_pop_tree_id  in  LEVEL*log2(TREE_NUM)  tree of returned result
- i_pop_data  in  LEVEL*(PTW+MTW)  returned result
- o_rsp_valid  out  LEVEL  response valid per lane
- o_rsp_req  out  LEVEL*log2(NREQ)  destination requester
- o_rsp_tree  out  LEVEL*log2(TREE_NUM)  tree
- o_rsp_data  out  LEVEL*(PTW+MTW)  result
- o_pending  out  TREE_NUM*(log2(TAG_DEPTH)+1)  outstanding pops per tree
- o_err_orphan  out  1  sticky: pop result with no outstanding tag

## Operation
- Lane of a request = tree_id & (LEVEL-1).
- Each lane has a round-robin arbiter over requesters whose request maps to that lane. At most one grant per lane per cycle, so push and pop are never raised on the same lane together.
- A requester is eligible when all of the following hold:
  - valid;
  - lane not full (!i_task_fifo_full[lane]);
  - for pops, target tree's tag FIFO is not full.
- On grant:
  - o_req_ready[r]=1.
  - Lane outputs are driven: o_push or o_pop, o_tree_id, and o_push_data (all-zero for a pop).
  - The lane's RR pointer moves to r+1 mod NREQ.
  - The pointer holds when there is no grant.
- On a pop grant, requester id r is written into the target tree's tag FIFO (TREE_NUM FIFOs, depth TAG_DEPTH).
- Pop results for a tree return in issue order.
- On i_is_level0_pop[k]:
  - The head of the tag FIFO for i_pop_tree_id[k] is popped.
  - A response is emitted on lane k with that requester id, the tree, and the data.
- Several lanes may return in the same cycle. Each targets a distinct tree, so responses are independent.
- Same tree, same cycle, grant push-to-tag plus return pop-from-tag: both are applied and the count is unchanged.
  - If the FIFO was empty, the return is an orphan.
- Orphan (return while tag FIFO empty):
  - no response;
  - o_err_orphan set, cleared only by reset;
  - FIFO pointers unchanged.
- o_pending[t] = tag FIFO occupancy, 0..TAG_DEPTH.
  - Pointer width is log2(TAG_DEPTH)+1 with wrap-around.
  - Full is when the MSBs differ and the low bits are equal.

## Timing
- Issue path is combinational, same cycle: valid → ready/o_push/o_pop. A lane transfers only when full is low in that cycle.
- A request not granted must be held stable by the requester until ready.
- Response latency is 1 cycle: i_is_level0_pop at edge n produces o_rsp_valid at edge n+1. Outputs are registered.
- Tag write is visible to a return in the next cycle; the same-cycle case follows the rule above.
- Reset, asynchronous, takes effect immediately, including mid-operation. Reset values:
  - RR pointers 0;
  - tag FIFOs empty, so o_pending all 0;
  - o_rsp_* all 0;
  - o_err_orphan 0.
- Combinational outputs under reset: o_req_ready, o_push, o_pop, o_tree_id and o_push_data forced 0 while i_arst_n is low.

## Test plan
- Fairness on one lane:
  - Stimulus: NREQ=4, all 4 requesters continuously push tree 1 (lane 1).
  - Required response: grants 0,1,2,3,0… one per cycle; o_push=4'b0010 every cycle.
- Parallel lanes:
  - Stimulus: requesters 0–3 push trees 0–3 simultaneously.
  - Required response: all ready in the same cycle; o_push=4'b1111; each lane carries its requester's data.
- Backpressure:
  - Stimulus: hold i_task_fifo_full[2]=1 for 5 cycles with requester 1 pushing tree 2.
  - Required response: no ready and o_push[2]=0 for those 5 cycles; grant in the cycle full drops.
- Response routing:
  - Stimulus: requesters 2 then 0 pop tree 3; two level-0 returns on lane 3 with data 0x00AA then 0x00BB.
  - Required response: o_rsp_req=2 with 0x00AA, then o_rsp_req=0 with 0x00BB, each 1 cycle after its return; o_pending[3] goes 0→1→2→1→0.
- Tag full:
  - Stimulus: 8 pops to tree 0 with no returns, then a 9th pop.
  - Required response: 9th pop not ready and o_pending[0]=8; one return frees it.
- Orphan and reset:
  - Stimulus: a return on tree 1 with an empty tag FIFO, then reset asserted mid-stream.
  - Required response: no o_rsp_valid; o_err_orphan=1. After reset: all outputs 0 and pointers 0.
